// File: rtl/fire_expand_scheduler.sv
// Shared fire2/fire3 expand MAC array scheduler: grants fire2 then fire3, walks pixel/channel addresses.
// Latency: enable rises the cycle after a sampled request; back-pressure stalls only at pixel boundaries.
module fire_expand_scheduler #(
    parameter int WOUT  = 64,
    parameter int CHIN  = 16,
    parameter int DRAIN = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fire2_req_i,
    input  logic                            fire3_req_i,
    input  logic                            ram_ready_i,
    output logic                            fire2_en_o,
    output logic                            fire3_en_o,
    output logic [$clog2(WOUT*WOUT)-1:0]    pix_addr_o,
    output logic [$clog2(CHIN+1)-1:0]       ch_addr_o,
    output logic                            sel_o,
    output logic                            busy_o,
    output logic                            fire2_done_o,
    output logic                            fire3_done_o
);

    localparam int PIXW = $clog2(WOUT*WOUT);
    localparam int CHW  = $clog2(CHIN+1);
    localparam int DW   = $clog2(DRAIN+1);

    localparam logic [PIXW-1:0] PIX_LAST   = PIXW'(WOUT*WOUT-1);
    localparam logic [CHW-1:0]  CH_LAST    = CHW'(CHIN);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [PIXW-1:0] r_pix,     w_pix_nxt;
    logic [CHW-1:0]  r_ch,      w_ch_nxt;
    logic            r_sel,     w_sel_nxt;
    logic            r_served2, w_served2_nxt;
    logic            r_served3, w_served3_nxt;
    logic [DW-1:0]   r_drain,   w_drain_nxt;

    logic w_fire2_en;
    logic w_fire3_en;
    logic w_busy;
    logic w_fire2_done;
    logic w_fire3_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pix     <= '0;
            r_ch      <= '0;
            r_sel     <= 1'b0;
            r_served2 <= 1'b0;
            r_served3 <= 1'b0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix     <= w_pix_nxt;
            r_ch      <= w_ch_nxt;
            r_sel     <= w_sel_nxt;
            r_served2 <= w_served2_nxt;
            r_served3 <= w_served3_nxt;
            r_drain   <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_nxt     = r_pix;
        w_ch_nxt      = r_ch;
        w_sel_nxt     = r_sel;
        w_served2_nxt = r_served2;
        w_served3_nxt = r_served3;
        w_drain_nxt   = r_drain;
        w_fire2_en    = 1'b0;
        w_fire3_en    = 1'b0;
        w_busy        = 1'b1;
        w_fire2_done  = 1'b0;
        w_fire3_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                // fire3 may only follow a completed fire2 layer
                if (fire2_req_i && !r_served2) begin
                    w_state_nxt = S_RUN;
                    w_sel_nxt   = 1'b0;
                    w_pix_nxt   = '0;
                    w_ch_nxt    = '0;
                end else if (fire3_req_i && r_served2 && !r_served3) begin
                    w_state_nxt = S_RUN;
                    w_sel_nxt   = 1'b1;
                    w_pix_nxt   = '0;
                    w_ch_nxt    = '0;
                end
            end
            S_RUN: begin
                w_fire2_en = !r_sel;
                w_fire3_en = r_sel;
                if (r_ch == CH_LAST) begin
                    w_ch_nxt = '0;
                    if (r_pix == PIX_LAST) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_pix_nxt = r_pix + PIXW'(1);
                        if (!ram_ready_i) begin
                            w_state_nxt = S_STALL;
                        end
                    end
                end else begin
                    w_ch_nxt = r_ch + CHW'(1);
                end
            end
            S_STALL: begin
                if (ram_ready_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                // lets the final clear slot flow through the datapath pipeline
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            S_DONE: begin
                w_fire2_done = !r_sel;
                w_fire3_done = r_sel;
                if (r_sel) begin
                    w_served3_nxt = 1'b1;
                end else begin
                    w_served2_nxt = 1'b1;
                end
                w_pix_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fire2_en_o   = w_fire2_en;
    assign fire3_en_o   = w_fire3_en;
    assign busy_o       = w_busy;
    assign fire2_done_o = w_fire2_done;
    assign fire3_done_o = w_fire3_done;
    assign pix_addr_o   = r_pix;
    assign ch_addr_o    = r_ch;
    assign sel_o        = r_sel;

endmodule

// File: tb/tb_fire_expand_scheduler.sv
// Directed bench for fire_expand_scheduler with a small geometry (WOUT=4, CHIN=2, DRAIN=4).
// Scenario table plus hand sequences for ordering and mid-layer reset.
module tb_fire_expand_scheduler;

    localparam int WOUT  = 4;
    localparam int CHIN  = 2;
    localparam int DRAIN = 4;

    logic       clk;
    logic       rst;
    logic       fire2_req_i;
    logic       fire3_req_i;
    logic       ram_ready_i;
    logic       fire2_en_o;
    logic       fire3_en_o;
    logic [3:0] pix_addr_o;
    logic [1:0] ch_addr_o;
    logic       sel_o;
    logic       busy_o;
    logic       fire2_done_o;
    logic       fire3_done_o;

    fire_expand_scheduler #(
        .WOUT (WOUT),
        .CHIN (CHIN),
        .DRAIN(DRAIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fire2_req_i (fire2_req_i),
        .fire3_req_i (fire3_req_i),
        .ram_ready_i (ram_ready_i),
        .fire2_en_o  (fire2_en_o),
        .fire3_en_o  (fire3_en_o),
        .pix_addr_o  (pix_addr_o),
        .ch_addr_o   (ch_addr_o),
        .sel_o       (sel_o),
        .busy_o      (busy_o),
        .fire2_done_o(fire2_done_o),
        .fire3_done_o(fire3_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    r2;
        bit    r3;
        int    spix;
        int    slen;
        int    mpix;
        int    ticks;
        int    x_en2;
        int    x_en3;
        int    x_first2;
        int    x_done2;
        int    x_first3;
        int    x_done3;
        int    x_busy;
    } vec_t;

    vec_t vt [4];

    int errors = 0;
    int checks = 0;

    int cyc, en2, en3, d2, d3, first2, first3, d2cyc, d3cyc;
    int seq_err, overlap, stall_err, busy_cnt;
    int e2ch, e2pix, e3ch, e3pix;
    int stall_pix = -1;
    int stall_len = 0;
    int stall_rem = 0;
    int mid_pix   = -1;
    bit stall_fired;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; en2 = 0; en3 = 0; d2 = 0; d3 = 0;
        first2 = 0; first3 = 0; d2cyc = 0; d3cyc = 0;
        seq_err = 0; overlap = 0; stall_err = 0; busy_cnt = 0;
        e2ch = 0; e2pix = 0; e3ch = 0; e3pix = 0;
        stall_rem = 0; stall_fired = 1'b0;
    endtask

    task automatic tick();
        bit en;
        @(posedge clk);
        #1;
        cyc++;
        en = fire2_en_o || fire3_en_o;
        if (fire2_en_o && fire3_en_o) overlap++;
        if (busy_o) busy_cnt++;
        if (fire2_en_o) begin
            en2++;
            if (first2 == 0) first2 = cyc;
            if (sel_o !== 1'b0 || int'(ch_addr_o) != e2ch || int'(pix_addr_o) != e2pix) seq_err++;
            if (e2ch == CHIN) begin e2ch = 0; e2pix++; end else e2ch++;
        end
        if (fire3_en_o) begin
            en3++;
            if (first3 == 0) first3 = cyc;
            if (sel_o !== 1'b1 || int'(ch_addr_o) != e3ch || int'(pix_addr_o) != e3pix) seq_err++;
            if (e3ch == CHIN) begin e3ch = 0; e3pix++; end else e3ch++;
        end
        if (fire2_done_o) begin d2++; d2cyc = cyc; end
        if (fire3_done_o) begin d3++; d3cyc = cyc; end

        // back-pressure injection: drop ready across the pixel boundary, hold it low stall_len cycles
        if (stall_rem > 0) begin
            if (en || !busy_o || int'(pix_addr_o) != stall_pix + 1 || ch_addr_o != 2'd0) stall_err++;
            stall_rem--;
            if (stall_rem == 0) ram_ready_i = 1'b1;
        end else if (stall_pix >= 0 && !stall_fired && en &&
                     int'(pix_addr_o) == stall_pix && int'(ch_addr_o) == CHIN) begin
            ram_ready_i = 1'b0;
            stall_rem   = stall_len;
            stall_fired = 1'b1;
        end
        if (mid_pix >= 0 && en && int'(pix_addr_o) == mid_pix) begin
            if (ch_addr_o == 2'd0) ram_ready_i = 1'b0;
            else if (int'(ch_addr_o) == CHIN) ram_ready_i = 1'b1;
        end
    endtask

    task automatic do_reset(input string name);
        fire2_req_i = 1'b0;
        fire3_req_i = 1'b0;
        ram_ready_i = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        chk({name, "_reset_outputs"},
            int'({fire2_en_o, fire3_en_o, sel_o, busy_o, fire2_done_o, fire3_done_o,
                  pix_addr_o, ch_addr_o}), 0);
        rst = 1'b1;
        clear_stats();
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        fire2_req_i = 1'b0;
        fire3_req_i = 1'b0;
        ram_ready_i = 1'b1;
        clear_stats();

        //          name      r2 r3 spix slen mpix ticks en2 en3 f2 dn2 f3 dn3 busy
        vt[0] = '{"basic",    1, 0, -1,  0,  -1,  120,  48, 0,  1, 53, 0,  0,  53};
        vt[1] = '{"both",     1, 1, -1,  0,  -1,  320,  48, 48, 1, 53, 55, 107, 106};
        vt[2] = '{"stall",    1, 0,  5, 10,  -1,  120,  48, 0,  1, 63, 0,  0,  63};
        vt[3] = '{"middrop",  1, 0, -1,  0,   3,  120,  48, 0,  1, 53, 0,  0,  53};

        for (int i = 0; i < 4; i++) begin
            do_reset(vt[i].name);
            stall_pix   = vt[i].spix;
            stall_len   = vt[i].slen;
            mid_pix     = vt[i].mpix;
            fire2_req_i = vt[i].r2;
            fire3_req_i = vt[i].r3;
            repeat (vt[i].ticks) tick();
            chk({vt[i].name, "_en2_cycles"}, en2, vt[i].x_en2);
            chk({vt[i].name, "_en3_cycles"}, en3, vt[i].x_en3);
            chk({vt[i].name, "_first_en2"}, first2, vt[i].x_first2);
            chk({vt[i].name, "_first_en3"}, first3, vt[i].x_first3);
            chk({vt[i].name, "_done2_cycle"}, d2cyc, vt[i].x_done2);
            chk({vt[i].name, "_done3_cycle"}, d3cyc, vt[i].x_done3);
            chk({vt[i].name, "_done2_pulses"}, d2, (vt[i].x_done2 != 0) ? 1 : 0);
            chk({vt[i].name, "_done3_pulses"}, d3, (vt[i].x_done3 != 0) ? 1 : 0);
            chk({vt[i].name, "_busy_cycles"}, busy_cnt, vt[i].x_busy);
            chk({vt[i].name, "_addr_sequence_errs"}, seq_err, 0);
            chk({vt[i].name, "_en_overlap"}, overlap, 0);
            if (vt[i].spix >= 0) begin
                chk({vt[i].name, "_stall_seen"}, int'(stall_fired), 1);
                chk({vt[i].name, "_stall_hold_errs"}, stall_err, 0);
            end
        end
        stall_pix = -1;
        mid_pix   = -1;

        // fire3 alone must wait for fire2
        do_reset("order");
        fire3_req_i = 1'b1;
        repeat (100) tick();
        chk("order_no_grant_busy", busy_cnt, 0);
        chk("order_no_grant_en", en2 + en3, 0);
        clear_stats();
        fire2_req_i = 1'b1;
        repeat (120) tick();
        chk("order_first_en2", first2, 1);
        chk("order_en2_cycles", en2, 48);
        chk("order_done2_cycle", d2cyc, 53);
        chk("order_first_en3", first3, 55);
        chk("order_en3_cycles", en3, 48);
        chk("order_done3_cycle", d3cyc, 107);
        chk("order_addr_sequence_errs", seq_err, 0);

        // reset in the middle of fire2
        do_reset("midrst");
        fire2_req_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (fire2_en_o && pix_addr_o == 4'd9) found = 1'b1;
        end
        chk("midrst_reached_pix9", int'(found), 1);
        rst = 1'b0;
        tick();
        chk("midrst_outputs_zero",
            int'({fire2_en_o, fire3_en_o, sel_o, busy_o, fire2_done_o, fire3_done_o,
                  pix_addr_o, ch_addr_o}), 0);
        chk("midrst_no_done", d2 + d3, 0);
        rst = 1'b1;
        clear_stats();
        tick();
        chk("midrst_restart_en2", int'(fire2_en_o), 1);
        chk("midrst_restart_pix", int'(pix_addr_o), 0);
        chk("midrst_restart_ch", int'(ch_addr_o), 0);
        repeat (60) tick();
        chk("midrst_en2_cycles", en2, 48);
        chk("midrst_done2_pulses", d2, 1);
        chk("midrst_done2_cycle", d2cyc, 53);
        chk("midrst_addr_sequence_errs", seq_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
